// File: rtl/button_debouncer.sv
// Two-flop synchroniser followed by a four-state debounce FSM; btn_db only
// moves after the synchronised input has held a new level for STABLE_CYCLES.
module button_debouncer #(
  parameter int STABLE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_db,
  output logic busy,
  output logic glitch
);

  localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    LOW,
    WAIT_HIGH,
    HIGH,
    WAIT_LOW
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          db_nxt, glitch_nxt;
  logic          s1, s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn_in;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= LOW;
      cnt    <= '0;
      btn_db <= 1'b0;
      glitch <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      btn_db <= db_nxt;
      glitch <= glitch_nxt;
    end
  end

  // A level that disappears before the final count aborts, even on the last cycle.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    db_nxt     = btn_db;
    glitch_nxt = 1'b0;
    case (state)
      LOW: begin
        if (s2) begin
          state_nxt = WAIT_HIGH;
          cnt_nxt   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!s2) begin
          state_nxt  = LOW;
          cnt_nxt    = '0;
          glitch_nxt = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_nxt = HIGH;
          cnt_nxt   = '0;
          db_nxt    = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      HIGH: begin
        if (!s2) begin
          state_nxt = WAIT_LOW;
          cnt_nxt   = '0;
        end
      end
      WAIT_LOW: begin
        if (s2) begin
          state_nxt  = HIGH;
          cnt_nxt    = '0;
          glitch_nxt = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_nxt = LOW;
          cnt_nxt   = '0;
          db_nxt    = 1'b0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = LOW;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign busy = (state == WAIT_HIGH) || (state == WAIT_LOW);

endmodule

// File: tb/tb_button_debouncer.sv
// Directed test-plan scenarios plus random button activity, checked each cycle
// against a run-length model of the debouncer.
module tb_button_debouncer;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_in = 1'b0;
  logic btn_db, busy, glitch;

  int checks = 0;
  int failures = 0;

  logic m_db = 1'b0;
  logic m_glitch = 1'b0;
  int   m_run = 0;
  int   m_rises = 0;
  logic m_hist[$];

  int   dut_rises = 0;
  logic prev_db = 1'b0;

  always #5 clk = ~clk;

  button_debouncer #(.STABLE_CYCLES(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .btn_in(btn_in),
    .btn_db(btn_db),
    .busy  (busy),
    .glitch(glitch)
  );

  // The FSM acts on the sample taken two edges earlier; a level differing from
  // the output must be seen N+1 times in a row to commit, and any return aborts.
  task automatic modelEdge(input logic b, input logic r);
    logic obs;
    if (r) begin
      m_hist.delete();
      m_db     = 1'b0;
      m_glitch = 1'b0;
      m_run    = 0;
    end else begin
      obs = (m_hist.size() >= 2) ? m_hist[m_hist.size()-2] : 1'b0;
      m_hist.push_back(b);
      if (m_hist.size() > 4) void'(m_hist.pop_front());
      m_glitch = 1'b0;
      if (obs != m_db) begin
        m_run++;
        if (m_run == N + 1) begin
          m_db  = obs;
          m_run = 0;
          if (obs) m_rises++;
        end
      end else if (m_run > 0) begin
        m_glitch = 1'b1;
        m_run    = 0;
      end
    end
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%b expected=%b at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkInt(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkOutput();
    checkBit("btn_db", btn_db, m_db);
    checkBit("busy", busy, m_run > 0);
    checkBit("glitch", glitch, m_glitch);
    checkInt("rises", dut_rises, m_rises);
  endtask

  task automatic applyStimulus(input logic b, input logic r);
    btn_in = b;
    rst    = r;
    @(posedge clk);
    modelEdge(b, r);
    #1;
    if (r) prev_db = 1'b0;
    else begin
      if (btn_db === 1'b1 && prev_db === 1'b0) dut_rises++;
      prev_db = btn_db;
    end
    checkOutput();
  endtask

  initial begin
    int len;
    logic lvl;

    $display("[TB] reset with input low");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 1'b0);
      checkBit("idle_db", btn_db, 1'b0);
    end

    $display("[TB] clean press");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b0);
      if (i >= 2 && i <= 5) checkBit("press_busy", busy, 1'b1);
      if (i == 5) checkBit("press_db_early", btn_db, 1'b0);
      if (i == 6) begin
        checkBit("press_db", btn_db, 1'b1);
        checkBit("press_busy_done", busy, 1'b0);
      end
    end

    $display("[TB] clean release");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b0);
      if (i == 5) checkBit("release_db_early", btn_db, 1'b1);
      if (i == 6) checkBit("release_db", btn_db, 1'b0);
      checkBit("release_glitch", glitch, 1'b0);
    end

    $display("[TB] short bounce");
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    for (int i = 2; i < 10; i++) begin
      applyStimulus(1'b0, 1'b0);
      if (i == 3) checkBit("bounce_busy", busy, 1'b1);
      if (i == 4) begin
        checkBit("bounce_glitch", glitch, 1'b1);
        checkBit("bounce_busy_drop", busy, 1'b0);
      end
      if (i == 5) checkBit("bounce_glitch_end", glitch, 1'b0);
      checkBit("bounce_db", btn_db, 1'b0);
    end

    $display("[TB] reset mid-qualification");
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1);
    checkBit("midrst_busy", busy, 1'b0);
    checkBit("midrst_db", btn_db, 1'b0);
    checkBit("midrst_glitch", glitch, 1'b0);
    for (int j = 0; j < 8; j++) begin
      applyStimulus(1'b1, 1'b0);
      if (j == 5) checkBit("midrst_db_early", btn_db, 1'b0);
      if (j == 6) checkBit("midrst_db_rise", btn_db, 1'b1);
    end
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0);
    checkInt("rises_before_chatter", dut_rises, 2);

    $display("[TB] chatter");
    for (int i = 0; i < 20; i++) begin
      applyStimulus((i % 2) == 0, 1'b0);
      checkBit("chatter_db", btn_db, 1'b0);
    end
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b0);
      checkBit("chatter_db", btn_db, 1'b0);
    end
    checkInt("chatter_rises", dut_rises, 2);

    $display("[TB] random activity");
    lvl = 1'b0;
    for (int i = 0; i < 60; i++) begin
      lvl = ~lvl;
      len = int'($urandom_range(1, 2 * N + 3));
      for (int j = 0; j < len; j++)
        applyStimulus(lvl, ($urandom_range(0, 49) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/button_debouncer.md
# button_debouncer

Synchronises and debounces a raw, asynchronous push-button or switch input and produces a clean level signal. Its `btn_db` output feeds the `sig` input of the positive-edge-detector stage directly downstream, which turns each debounced press into a one-cycle pulse. A bounce-free level is required there; raw contact chatter would otherwise produce multiple edge pulses per press.

## Interface
- `STABLE_CYCLES`, default 1000000: number of consecutive cycles the synchronised input must hold a new level before `btn_db` follows. Legal range is ≥ 1. The default gives 10 ms at 100 MHz.
- Counter width: local, `$clog2(STABLE_CYCLES)`, minimum 1 bit. Not user-settable.

Ports:
- `clk`  in  1  single system clock; all logic is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `btn_in`  in  1  raw button level; asynchronous to `clk` and may bounce.
- `btn_db`  out  1  debounced level; drives the downstream edge detector's `sig`.
- `busy`  out  1  high while a level change is being qualified.
- `glitch`  out  1  one-cycle pulse when a qualification is aborted by a bounce.

## Operation
- **Synchroniser:** two flops, `btn_in` → `s1` → `s2`. The FSM uses only `s2`.
- **FSM states:** `LOW`, `WAIT_HIGH`, `HIGH`, `WAIT_LOW`. The counter `cnt` has width equal to the counter width above.
- **`LOW`:**
  - `s2`=1 → `WAIT_HIGH`, `cnt`←0.
  - Otherwise stay.
- **`WAIT_HIGH`:**
  - `s2`=0 → `LOW`, `cnt`←0, `glitch`←1.
  - Else if `cnt`==`STABLE_CYCLES`-1 → `HIGH`, `btn_db`←1, `cnt`←0.
  - Else `cnt`←`cnt`+1.
- **`HIGH` / `WAIT_LOW`:** mirror of the above with polarities swapped; `btn_db`←0 on entering `LOW`.
- **Output decode:**
  - `btn_db` is a register that changes only on `WAIT_*` → stable transitions.
  - `busy` = (state is `WAIT_HIGH` or `WAIT_LOW`), decoded from the state register only.
  - `glitch` is registered and defaults to 0 every cycle, except on an aborted `WAIT_*`.
- **Counter:** `cnt` never exceeds `STABLE_CYCLES`-1 and never wraps. It is cleared on every state change.
- **Reset:**
  - `rst` has priority over all transitions.
  - Reset values: `s1`=`s2`=0, state=`LOW`, `cnt`=0, `btn_db`=0, `busy`=0, `glitch`=0.
  - Reset mid-`WAIT_*` abandons qualification with no `glitch` pulse.
- **Button held during reset:** if `btn_in`=1 through reset, the block re-qualifies from `LOW` after release. `btn_db` then rises after the full latency, and the downstream stage sees exactly one rising edge.
- **Boundary conditions:**
  - `STABLE_CYCLES`=1: `WAIT_*` lasts exactly one cycle when the input is stable.
  - A bounce on the exact cycle `cnt`==`STABLE_CYCLES`-1 aborts; it does not commit.

## Timing
- Let edge k be the first clock edge at which `s1` samples `btn_in`=1. Let N = `STABLE_CYCLES`.
- `s2`=1 after edge k+1. The FSM enters `WAIT_HIGH` at edge k+2, so `busy`=1 after edge k+2.
- The input must be sampled high at edges k … k+N (N+1 samples).
- `btn_db`=1 and `busy`=0 after edge k+N+2. Total latency is N+2 cycles.
- Falling transitions have identical latency.
- **Abort:** if the first low sample is at edge k+m with 2 ≤ m ≤ N, the FSM sees it at edge k+m+2.
  - `glitch`=1 for exactly the cycle after edge k+m+2.
  - The state returns to `LOW` and `btn_db` is unchanged.
- Minimum spacing between two committed `btn_db` changes is N+1 cycles.

## Test plan
Use `STABLE_CYCLES`=4 for all scenarios.
1. **Reset, input low:** hold `rst`=1 for 3 cycles with `btn_in`=0 → `btn_db`=0, `busy`=0, `glitch`=0 throughout, and for 20 cycles after release.
2. **Clean press:** `btn_in` goes 0→1 (first sampled at edge k) and holds 10 cycles → `busy`=1 after edges k+2 … k+5. `btn_db`=1 and `busy`=0 after edge k+6. `glitch` stays 0.
3. **Short bounce:** `btn_in` is 1 for 2 samples (edges k, k+1), then 0 → `glitch`=1 only in the cycle after edge k+4. `btn_db` stays 0 and `busy` drops after edge k+4.
4. **Clean release:** from `HIGH`, `btn_in` goes 1→0 (first sampled at edge j) → `btn_db`=0 after edge j+6. No `glitch`.
5. **Reset mid-qualification:** assert `rst` at edge k+4 of a press with `btn_in` still 1 → after that edge `busy`=0, `btn_db`=0, `glitch`=0. Deassert at edge k+5 → `btn_db`=1 after edge k+11 (full N+2 from the new first sample at k+5).
6. **Chatter:** `btn_in` toggles every cycle for 20 cycles, then holds 0 → `btn_db` never changes, one `glitch` pulse per aborted `WAIT_HIGH`, and the downstream edge detector emits zero pulses.
